// File: rtl/i2c_pkg.sv
// Shared I2C definitions: register pointers, default device address, FSM state
// encoding and a majority-vote helper for the input filter.
package i2c_pkg;

    localparam logic [3:0] BASE_ADDR_DEFAULT = 4'b1001;

    localparam logic [7:0] PTR_TEMP_HI = 8'h00;
    localparam logic [7:0] PTR_TEMP_LO = 8'h01;
    localparam logic [7:0] PTR_CFG_RD  = 8'h03;
    localparam logic [7:0] PTR_CFG_WR  = 8'h09;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK
    } i2c_state_t;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// SCL/SDA conditioning: 2-flop synchronizer, optional 3-sample majority filter
// (I2C_SLAVE_GLITCH_FILTER_EN), then SCL edge and START/STOP detection.
module i2c_line_cond
    import i2c_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [1:0] r_scl_sync;
    logic [1:0] r_sda_sync;
    logic       w_scl;
    logic       w_sda;
    logic       r_scl_d;
    logic       r_sda_d;

    // Reset to the idle bus level so leaving reset never looks like an edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
        end else begin
            r_scl_sync <= {r_scl_sync[0], i_scl};
            r_sda_sync <= {r_sda_sync[0], i_sda};
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] r_scl_hist;
    logic [1:0] r_sda_hist;
    logic       r_scl_f;
    logic       r_sda_f;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_scl_hist <= 2'b11;
            r_sda_hist <= 2'b11;
            r_scl_f    <= 1'b1;
            r_sda_f    <= 1'b1;
        end else begin
            r_scl_hist <= {r_scl_hist[0], r_scl_sync[1]};
            r_sda_hist <= {r_sda_hist[0], r_sda_sync[1]};
            r_scl_f    <= maj3({r_scl_hist, r_scl_sync[1]});
            r_sda_f    <= maj3({r_sda_hist, r_sda_sync[1]});
        end
    end

    assign w_scl = r_scl_f;
    assign w_sda = r_sda_f;
`else
    assign w_scl = r_scl_sync[1];
    assign w_sda = r_sda_sync[1];
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_scl_d <= 1'b1;
            r_sda_d <= 1'b1;
        end else begin
            r_scl_d <= w_scl;
            r_sda_d <= w_sda;
        end
    end

    assign o_sda      = w_sda;
    assign o_scl_rise = w_scl & ~r_scl_d;
    assign o_scl_fall = ~w_scl & r_scl_d;
    assign o_start    = w_scl & r_scl_d & ~w_sda & r_sda_d;
    assign o_stop     = w_scl & r_scl_d & w_sda & ~r_sda_d;

endmodule

// File: rtl/i2c_temp_slave.sv
// I2C temperature-sensor target: address match, pointer register, read-only
// temperature bytes with coherent low-byte shadow, read/write config register.
module i2c_temp_slave
    import i2c_pkg::*;
#(
    parameter logic [3:0] BASE_ADDR = BASE_ADDR_DEFAULT,
    parameter logic [7:0] CFG_RST   = 8'h00
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       SCL,
    inout  wire        SDA,
    input  logic [2:0] adr,
    input  logic [7:0] temp_hi,
    input  logic [7:0] temp_lo,
    output logic [7:0] cfg,
    output logic       cfg_wr,
    output logic       busy
);

    i2c_state_t r_state;
    i2c_state_t w_next;

    logic       w_sda;
    logic       w_rise;
    logic       w_fall;
    logic       w_start;
    logic       w_stop;
    logic       w_last;
    logic       w_match;
    logic [7:0] w_byte;
    logic [7:0] w_rd_byte;

    logic [2:0] r_bit_cnt;
    logic [6:0] r_shift;
    logic [6:0] r_tx;
    logic [7:0] r_ptr;
    logic [7:0] r_shadow;
    logic [7:0] r_cfg;
    logic       r_cfg_wr;
    logic       r_busy;
    logic       r_rw;
    logic       r_ack_ph;
    logic       r_sda_low;

    i2c_line_cond u_line_cond (
        .i_clk      (CLK),
        .i_rst_n    (RES),
        .i_scl      (SCL),
        .i_sda      (SDA),
        .o_sda      (w_sda),
        .o_scl_rise (w_rise),
        .o_scl_fall (w_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    assign w_byte  = {r_shift, w_sda};
    assign w_last  = w_rise && (r_bit_cnt == 3'd7);
    assign w_match = (w_byte[7:1] == {BASE_ADDR, adr});

    always_comb begin
        w_rd_byte = 8'h00;
        case (r_ptr)
            PTR_TEMP_HI: w_rd_byte = temp_hi;
            PTR_TEMP_LO: w_rd_byte = r_shadow;
            PTR_CFG_RD:  w_rd_byte = r_cfg;
            default:     w_rd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RES) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    // NOTE: every path starts from the held state, so no latch is inferred.
    always_comb begin
        w_next = r_state;
        if (w_stop) begin
            w_next = ST_IDLE;
        end else if (w_start) begin
            w_next = ST_ADDR;
        end else begin
            case (r_state)
                ST_ADDR:      if (w_last) w_next = w_match ? ST_ADDR_ACK : ST_IDLE;
                ST_ADDR_ACK:  if (w_fall && r_ack_ph) w_next = r_rw ? ST_RDATA : ST_PTR;
                ST_PTR:       if (w_last) w_next = ST_PTR_ACK;
                ST_PTR_ACK:   if (w_fall && r_ack_ph) w_next = ST_WDATA;
                ST_WDATA:     if (w_last) w_next = ST_WDATA_ACK;
                ST_WDATA_ACK: if (w_fall && r_ack_ph) w_next = ST_WDATA;
                ST_RDATA:     if (w_last) w_next = ST_RDATA_ACK;
                ST_RDATA_ACK: begin
                    // Master NACK ends the read at the 9th rising edge.
                    if (w_rise && r_ack_ph && w_sda) w_next = ST_IDLE;
                    else if (w_fall && r_ack_ph)     w_next = ST_RDATA;
                end
                default:      w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RES) begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 7'd0;
            r_tx      <= 7'd0;
            r_ptr     <= PTR_TEMP_HI;
            r_shadow  <= 8'h00;
            r_cfg     <= CFG_RST;
            r_cfg_wr  <= 1'b0;
            r_busy    <= 1'b0;
            r_rw      <= 1'b0;
            r_ack_ph  <= 1'b0;
            r_sda_low <= 1'b0;
        end else begin
            r_cfg_wr <= 1'b0;
            if (w_stop) begin
                r_sda_low <= 1'b0;
                r_busy    <= 1'b0;
            end else if (w_start) begin
                r_sda_low <= 1'b0;
                r_bit_cnt <= 3'd0;
            end else begin
                case (r_state)
                    ST_ADDR, ST_PTR, ST_WDATA: begin
                        if (w_rise) begin
                            r_shift   <= w_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_ack_ph  <= 1'b0;
                            if (w_last && r_state == ST_ADDR && w_match) begin
                                r_rw   <= w_byte[0];
                                r_busy <= 1'b1;
                            end
                            if (w_last && r_state == ST_PTR) r_ptr <= w_byte;
                            if (w_last && r_state == ST_WDATA && r_ptr == PTR_CFG_WR) begin
                                r_cfg    <= w_byte;
                                r_cfg_wr <= 1'b1;
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (w_rise) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_ack_ph  <= 1'b0;
                        end else if (w_fall) begin
                            r_tx      <= {r_tx[5:0], 1'b0};
                            r_sda_low <= ~r_tx[6];
                        end
                    end
                    ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK, ST_RDATA_ACK: begin
                        if (w_fall && !r_ack_ph) begin
                            // 8th falling edge: drive our ACK, or release for the master's.
                            r_ack_ph  <= 1'b1;
                            r_sda_low <= (r_state != ST_RDATA_ACK);
                        end else if (w_fall) begin
                            r_bit_cnt <= 3'd0;
                            r_sda_low <= 1'b0;
                            if (w_next == ST_RDATA) begin
                                r_tx      <= w_rd_byte[6:0];
                                r_sda_low <= ~w_rd_byte[7];
                                if (r_ptr == PTR_TEMP_HI) r_shadow <= temp_lo;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign SDA    = r_sda_low ? 1'b0 : 1'bz;
    assign cfg    = r_cfg;
    assign cfg_wr = r_cfg_wr;
    assign busy   = r_busy;

endmodule

// File: tb/tb_i2c_temp_slave.sv
// Self-checking bench for i2c_temp_slave: a bit-level I2C master drives scripted and
// random transactions, checked against a register-map model of the sensor.
module tb_i2c_temp_slave;

    localparam logic [3:0] BASE      = 4'b1001;
    localparam logic [7:0] CFG_RST_V = 8'h00;

    logic       clk   = 1'b0;
    logic       res_n = 1'b0;
    logic       scl   = 1'b1;
    logic       m_low = 1'b0;
    logic [2:0] adr   = 3'b101;
    logic [7:0] temp_hi = 8'h00;
    logic [7:0] temp_lo = 8'h00;
    logic [7:0] cfg;
    logic       cfg_wr;
    logic       busy;
    wire        sda_line;

    pullup (sda_line);
    assign sda_line = m_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_temp_slave #(
        .BASE_ADDR (BASE),
        .CFG_RST   (CFG_RST_V)
    ) dut (
        .CLK     (clk),
        .RES     (res_n),
        .SCL     (scl),
        .SDA     (sda_line),
        .adr     (adr),
        .temp_hi (temp_hi),
        .temp_lo (temp_lo),
        .cfg     (cfg),
        .cfg_wr  (cfg_wr),
        .busy    (busy)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus monitors: cfg_wr pulses and any CLK where the slave holds SDA low.
    int wr_pulses = 0;
    int slave_drv = 0;
    always @(posedge clk) begin
        if (cfg_wr) wr_pulses <= wr_pulses + 1;
        if (!m_low && sda_line == 1'b0) slave_drv <= slave_drv + 1;
    end

    // Reference model of the sensor's register map.
    logic [7:0] m_cfg    = CFG_RST_V;
    logic [7:0] m_ptr    = 8'h00;
    logic [7:0] m_shadow = 8'h00;

    function automatic logic [7:0] model_read();
        case (m_ptr)
            8'h00: begin m_shadow = temp_lo; return temp_hi; end
            8'h01: return m_shadow;
            8'h03: return m_cfg;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_cfg = CFG_RST_V; m_ptr = 8'h00; m_shadow = 8'h00;
    endtask

    // Bit-level master: SCL low phase 12 CLK (SDA changes mid-low), high phase 10 CLK.
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        if (scl == 1'b0) begin
            wait_clk(6); m_low = 1'b0; wait_clk(6); scl = 1'b1; wait_clk(6);
        end
        m_low = 1'b1; wait_clk(6); scl = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clk(6); m_low = 1'b1; wait_clk(6); scl = 1'b1; wait_clk(6); m_low = 1'b0; wait_clk(10);
    endtask

    task automatic send_bit(input logic b);
        wait_clk(6); m_low = ~b; wait_clk(6); scl = 1'b1; wait_clk(10); scl = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        wait_clk(6); m_low = 1'b0; wait_clk(6); scl = 1'b1; wait_clk(5); b = sda_line; wait_clk(5); scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack_low);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(b);
        ack_low = ~b;
    endtask

    task automatic recv_byte(input logic master_ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(~master_ack);
    endtask

    function automatic logic is_hit(input logic [6:0] a);
        return a == {BASE, adr};
    endfunction

    task automatic xfer_write(input logic [6:0] a, input logic [7:0] p, input int n,
                              input logic [7:0] d0, input logic [7:0] d1, input string tag);
        logic       ack;
        logic       hit;
        logic [7:0] d;
        int         p0;
        int         exp_p;
        hit   = is_hit(a);
        p0    = wr_pulses;
        exp_p = 0;
        bus_start();
        send_byte({a, 1'b0}, ack); check({tag, "/ack_addr"}, ack, hit);
        send_byte(p, ack);         check({tag, "/ack_ptr"}, ack, hit);
        if (hit) m_ptr = p;
        for (int i = 0; i < n; i++) begin
            d = (i == 0) ? d0 : d1;
            send_byte(d, ack); check({tag, "/ack_data"}, ack, hit);
            if (hit && m_ptr == 8'h09) begin m_cfg = d; exp_p++; end
        end
        check({tag, "/busy"}, busy, hit);
        bus_stop();
        check({tag, "/cfg"}, cfg, m_cfg);
        check({tag, "/pulses"}, wr_pulses - p0, exp_p);
        check({tag, "/busy_stop"}, busy, 1'b0);
    endtask

    task automatic read_part(input logic [6:0] a, input int n, input string tag);
        logic       ack;
        logic       hit;
        logic [7:0] d;
        logic [7:0] e;
        hit = is_hit(a);
        bus_start();
        send_byte({a, 1'b1}, ack); check({tag, "/ack_raddr"}, ack, hit);
        for (int i = 0; i < n; i++) begin
            e = hit ? model_read() : 8'hFF;
            recv_byte(i != n - 1, d);
            check({tag, "/rd"}, d, e);
        end
        check({tag, "/released"}, sda_line, 1'b1);
        check({tag, "/busy"}, busy, hit);
    endtask

    task automatic set_ptr_read(input logic [6:0] a, input logic [7:0] p, input int n, input string tag);
        logic ack;
        bus_start();
        send_byte({a, 1'b0}, ack); check({tag, "/ack_addr"}, ack, is_hit(a));
        send_byte(p, ack);         check({tag, "/ack_ptr"}, ack, is_hit(a));
        if (is_hit(a)) m_ptr = p;
        read_part(a, n, tag);
        bus_stop();
    endtask

    task automatic read_cur(input logic [6:0] a, input int n, input string tag);
        read_part(a, n, tag);
        bus_stop();
    endtask

    initial begin
        logic       ack;
        logic       b;
        int         drv0;
        logic [6:0] me;

        wait_clk(4);
        check("rst_cfg", cfg, CFG_RST_V);
        check("rst_cfg_wr", cfg_wr, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sda", sda_line, 1'b1);
        res_n = 1'b1;
        wait_clk(4);

        // Config write: 0x9A, 0x09, 0x20.
        xfer_write(7'h4D, 8'h09, 1, 8'h20, 8'h00, "cfgwr");

        // Temperature read via pointer 0x00 and repeated START.
        temp_hi = 8'h19; temp_lo = 8'h80;
        set_ptr_read(7'h4D, 8'h00, 1, "temp");

        // Shadow keeps the low byte captured with the high-byte read.
        temp_lo = 8'h40;
        set_ptr_read(7'h4D, 8'h01, 1, "snap");

        // Wrong address: slave must never touch SDA.
        drv0 = slave_drv;
        xfer_write(7'h48, 8'h09, 1, 8'hFF, 8'h00, "mismatch");
        check("mismatch/no_drive", slave_drv - drv0, 0);

        // STOP after 4 data bits aborts the cfg write.
        bus_start();
        send_byte(8'h9A, ack); check("abort/ack_addr", ack, 1'b1);
        send_byte(8'h09, ack); check("abort/ack_ptr", ack, 1'b1);
        m_ptr = 8'h09;
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        bus_stop();
        check("abort/cfg", cfg, m_cfg);
        check("abort/busy", busy, 1'b0);
        read_cur(7'h4D, 1, "abort_rd");

        // Randomized traffic across the register map.
        for (int it = 0; it < 14; it++) begin
            logic [6:0] a;
            logic [7:0] p;
            int         n;
            adr = 3'($urandom_range(0, 7));
            a   = {BASE, adr};
            if ($urandom_range(0, 3) == 0) begin
                a = 7'($urandom);
                if (a == {BASE, adr}) a = a ^ 7'h10;
            end
            case ($urandom_range(0, 4))
                0:       p = 8'h00;
                1:       p = 8'h01;
                2:       p = 8'h03;
                3:       p = 8'h09;
                default: p = 8'($urandom);
            endcase
            temp_hi = 8'($urandom);
            temp_lo = 8'($urandom);
            n = $urandom_range(1, 2);
            case ($urandom_range(0, 2))
                0:       xfer_write(a, p, n, 8'($urandom), 8'($urandom), "rnd_wr");
                1:       set_ptr_read(a, p, n, "rnd_ptr_rd");
                default: read_cur(a, n, "rnd_cur_rd");
            endcase
        end

        // Reset while the slave is driving a 0 data bit of a cfg read.
        adr = 3'b101;
        me  = {BASE, adr};
        xfer_write(me, 8'h09, 1, 8'h20, 8'h00, "pre_rst");
        bus_start();
        send_byte({me, 1'b0}, ack); check("rstrd/ack_addr", ack, 1'b1);
        send_byte(8'h03, ack);      check("rstrd/ack_ptr", ack, 1'b1);
        m_ptr = 8'h03;
        bus_start();
        send_byte({me, 1'b1}, ack); check("rstrd/ack_raddr", ack, 1'b1);
        for (int i = 0; i < 3; i++) recv_bit(b);
        wait_clk(6);
        check("rstrd/driving", sda_line, 1'b0);
        res_n = 1'b0;
        wait_clk(1);
        check("rstrd/sda_rel", sda_line, 1'b1);
        check("rstrd/cfg", cfg, CFG_RST_V);
        check("rstrd/busy", busy, 1'b0);
        res_n = 1'b1;
        model_reset();
        bus_stop();
        read_cur(me, 1, "post_rst");

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        // One-CLK SCL spike inside the address byte must not count as a bit.
        bus_start();
        send_bit(me[6]);
        send_bit(me[5]);
        wait_clk(3); scl = 1'b1; wait_clk(1); scl = 1'b0;
        for (int i = 4; i >= 0; i--) send_bit(me[i]);
        send_bit(1'b0);
        recv_bit(b);
        check("glitch/ack_addr", b, 1'b0);
        send_byte(8'h03, ack); check("glitch/ack_ptr", ack, 1'b1);
        m_ptr = 8'h03;
        bus_stop();
        read_cur(me, 1, "glitch_rd");
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
